// File: rtl/ahb_text_writer.sv
// AHB-Lite single-write master that streams 7-bit characters from a small FIFO
// to a fixed text display address, one NONSEQ write per character.
module ahb_text_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        reset,
    input  logic [6:0]  ch_data,
    input  logic        ch_valid,
    output logic        ch_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        err,
    output logic [15:0] wr_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    logic [6:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          init_q;
    logic          dphase_q;
    logic          blocked_q;
    logic          err_q;
    logic [31:0]   hwdata_q;
    logic [15:0]   wr_count_q;

    logic full, empty, push, nonseq, accept, err_first, data_ok;

    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        push      = ch_valid && ch_ready;
        // The cycle after an error's first cycle must not carry a NONSEQ.
        nonseq    = !empty && !blocked_q;
        accept    = nonseq && HREADY;
        err_first = dphase_q && HRESP && !HREADY;
        data_ok   = dphase_q && HREADY && !HRESP;
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ch_data;
        end
    end

    always_ff @(posedge HCLK) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            init_q     <= 1'b0;
            dphase_q   <= 1'b0;
            blocked_q  <= 1'b0;
            err_q      <= 1'b0;
            hwdata_q   <= '0;
            wr_count_q <= '0;
        end else begin
            init_q  <= 1'b1;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (accept) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                hwdata_q <= {25'b0, mem_q[rd_ptr_q]};
            end
            if (HREADY) begin
                dphase_q <= accept;
            end
            if (err_first) begin
                blocked_q <= 1'b1;
            end else if (HREADY) begin
                blocked_q <= 1'b0;
            end
            if (err_first) begin
                err_q <= 1'b1;
            end
            if (data_ok) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        ch_ready = init_q && !full;
        HTRANS   = nonseq ? TransNonseq : TransIdle;
        HWRITE   = nonseq;
        HADDR    = BASE_ADDR;
        HSIZE    = 3'b010;
        HBURST   = 3'b000;
        HPROT    = 4'b0011;
        HWDATA   = hwdata_q;
        busy     = !empty || dphase_q;
        err      = err_q;
        wr_count = wr_count_q;
    end

endmodule
